// File: rtl/cv32e40p_alu_select_ft_if.sv
// Bundle between the fault-tolerant EX stage and the ALU selection controller:
// fault matrix and issue info in, voter selection, counter enables and stall request out.
interface cv32e40p_alu_select_ft_if;
   logic [3:0][8:0] permanent_faulty_alu_i;
   logic            op_valid_i;
   logic [3:0]      op_class_i;
   logic            reconf_ack_i;
   logic            reconf_req_o;
   logic [2:0][1:0] alu_sel_o;
   logic [3:0]      counter_en_o;
   logic            no_redundancy_o;
   logic            all_faulty_o;
   logic [7:0]      reconf_count_o;

   modport master (
      output permanent_faulty_alu_i, op_valid_i, op_class_i, reconf_ack_i,
      input  reconf_req_o, alu_sel_o, counter_en_o, no_redundancy_o, all_faulty_o, reconf_count_o
   );

   modport slave (
      input  permanent_faulty_alu_i, op_valid_i, op_class_i, reconf_ack_i,
      output reconf_req_o, alu_sel_o, counter_en_o, no_redundancy_o, all_faulty_o, reconf_count_o
   );
endinterface

// File: rtl/cv32e40p_alu_select_ft.sv
// ALU selection / reconfiguration controller for the TMR EX stage.
// Optional spare rotation across four healthy ALUs: define FT_ALU_SPARE_ROTATE_EN.
module cv32e40p_alu_select_ft #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned N_CLASS       = 9
) (
   input logic                    clk_gated,
   input logic                    rst_n,
   cv32e40p_alu_select_ft_if.slave bus
);

   if (N_CLASS != 9) begin : g_bad_n_class
      $error("cv32e40p_alu_select_ft: N_CLASS must be 9");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("cv32e40p_alu_select_ft: SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      UPDATE,
      SETTLE
   } state_e;

   state_e          state_q, state_d;
   logic [3:0][8:0] snap_q;
   logic [3:0]      settle_cnt_q;
   logic [7:0]      reconf_count_q;
   logic [2:0][1:0] sel_q, sel_d;
   logic            no_red_q, no_red_d;
   logic            all_faulty_q, all_faulty_d;
   logic            new_fault;
   logic            op_accept;
   logic [3:0]      cls_idx;
   logic [3:0]      healthy;
   logic [2:0]      healthy_cnt;
   logic [1:0]      idx0, idx1, idx2;
   logic [3:0]      counter_en;
`ifdef FT_ALU_SPARE_ROTATE_EN
   logic [1:0]      rp_q;
`endif

   // Only faults not yet captured in the snapshot trigger a reconfiguration.
   assign new_fault = |(bus.permanent_faulty_alu_i & ~snap_q);
   assign op_accept = bus.op_valid_i && (state_q == IDLE);
   assign cls_idx   = (bus.op_class_i > 4'd8) ? 4'd0 : bus.op_class_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (new_fault) state_d = REQ;
         REQ:     if (bus.reconf_ack_i) state_d = UPDATE;
         UPDATE:  state_d = SETTLE;
         SETTLE:  if (settle_cnt_q == 4'd0) state_d = new_fault ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_gated) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         snap_q         <= '0;
         settle_cnt_q   <= 4'd0;
         reconf_count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         if (state_q == UPDATE) begin
            snap_q       <= snap_q | bus.permanent_faulty_alu_i;
            settle_cnt_q <= SETTLE_LAST;
            if (reconf_count_q != 8'hFF) reconf_count_q <= reconf_count_q + 8'd1;
         end else if (state_q == SETTLE && settle_cnt_q != 4'd0) begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
         end
      end
   end

   // Gather the three lowest healthy ALU indices for the issued class from the snapshot.
   always_comb begin
      healthy     = '0;
      healthy_cnt = 3'd0;
      idx0        = 2'd0;
      idx1        = 2'd0;
      idx2        = 2'd0;
      for (int a = 0; a < 4; a++) begin
         healthy[a] = ~snap_q[a][cls_idx];
         if (healthy[a]) begin
            case (healthy_cnt)
               3'd0:    idx0 = 2'(a);
               3'd1:    idx1 = 2'(a);
               3'd2:    idx2 = 2'(a);
               default: ;
            endcase
            healthy_cnt = healthy_cnt + 3'd1;
         end
      end
`ifdef FT_ALU_SPARE_ROTATE_EN
      if (healthy_cnt == 3'd4) begin
         idx0 = (rp_q == 2'd0) ? 2'd1 : 2'd0;
         idx1 = (rp_q <= 2'd1) ? 2'd2 : 2'd1;
         idx2 = (rp_q == 2'd3) ? 2'd2 : 2'd3;
      end
`endif
   end

   always_comb begin
      sel_d        = {idx2, idx1, idx0};
      no_red_d     = 1'b0;
      all_faulty_d = 1'b0;
      case (healthy_cnt)
         3'd0: begin
            sel_d        = '0;
            no_red_d     = 1'b1;
            all_faulty_d = 1'b1;
         end
         3'd1: begin
            sel_d    = {idx0, idx0, idx0};
            no_red_d = 1'b1;
         end
         3'd2: begin
            sel_d    = {idx0, idx1, idx0};
            no_red_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_gated) begin
      if (!rst_n) begin
         sel_q        <= {2'd2, 2'd1, 2'd0};
         no_red_q     <= 1'b0;
         all_faulty_q <= 1'b0;
      end else if (op_accept) begin
         sel_q        <= sel_d;
         no_red_q     <= no_red_d;
         all_faulty_q <= all_faulty_d;
      end
   end

`ifdef FT_ALU_SPARE_ROTATE_EN
   always_ff @(posedge clk_gated) begin
      if (!rst_n)         rp_q <= 2'd3;
      else if (op_accept) rp_q <= rp_q - 2'd1;
   end
`endif

   // Only ALUs feeding the voter may accumulate errors.
   always_comb begin
      counter_en = '0;
      for (int i = 0; i < 3; i++) counter_en[sel_q[i]] = 1'b1;
   end

   assign bus.reconf_req_o    = (state_q != IDLE);
   assign bus.alu_sel_o       = sel_q;
   assign bus.counter_en_o    = counter_en;
   assign bus.no_redundancy_o = no_red_q;
   assign bus.all_faulty_o    = all_faulty_q;
   assign bus.reconf_count_o  = reconf_count_q;

endmodule
